// File: rtl/dcache_dm_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with a burst line-refill FSM.
// Define DCACHE_STAT_EN to build the load hit/miss counters; otherwise both counter ports read 0.
module dcache_dm_wt #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LINE_NUM   = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_rd_req_i,
    input  logic                  cpu_wr_req_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data_i,
    input  logic [3:0]            cpu_wr_en_i,
    output logic [DATA_WIDTH-1:0] cpu_rd_data_o,
    output logic                  pipeline_stall_o,
    output logic                  cache_data_ack_o,
    output logic                  ram_rd_req_o,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
    input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
    input  logic                  ram_rd_valid_i,
    output logic                  ram_wr_req_o,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wr_data_o,
    output logic [3:0]            ram_wr_en_o,
    input  logic                  ram_wr_ack_i,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
);
    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int IDX_BITS  = $clog2(LINE_NUM);
    localparam int IDX_LSB   = 2 + WORD_BITS;
    localparam int TAG_BITS  = ADDR_WIDTH - IDX_LSB - IDX_BITS;
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(3));
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_WORDS * 4 - 1));
    localparam logic [WORD_BITS-1:0]  LAST_WORD = WORD_BITS'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, RESP, WRITE} state_t;

    state_t                 state_q, state_d;
    logic [LINE_NUM-1:0]    valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]  base_q, base_d;
    logic [WORD_BITS-1:0]   k_q, k_d;
    logic [WORD_BITS-1:0]   req_word_q, req_word_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [3:0]             wr_en_q, wr_en_d;

    logic [TAG_BITS-1:0]    tag_q  [LINE_NUM];
    logic [DATA_WIDTH-1:0]  data_q [LINE_NUM*LINE_WORDS];

    logic                          arr_we;
    logic [IDX_BITS+WORD_BITS-1:0] arr_sel;
    logic [DATA_WIDTH-1:0]         arr_wdata;
    logic                          tag_we;

    logic                  rd_req, wr_req, hit;
    logic [IDX_BITS-1:0]   cpu_idx, base_idx;
    logic [WORD_BITS-1:0]  cpu_word;
    logic [TAG_BITS-1:0]   cpu_tag, base_tag;
    logic [DATA_WIDTH-1:0] cpu_word_data, store_merged;

    // Requests are masked while reset is held so that every output stays 0.
    assign rd_req        = cpu_rd_req_i & rst_n;
    assign wr_req        = cpu_wr_req_i & rst_n;
    assign cpu_word      = cpu_addr_i[2 +: WORD_BITS];
    assign cpu_idx       = cpu_addr_i[IDX_LSB +: IDX_BITS];
    assign cpu_tag       = cpu_addr_i[ADDR_WIDTH-1 -: TAG_BITS];
    assign base_idx      = base_q[IDX_LSB +: IDX_BITS];
    assign base_tag      = base_q[ADDR_WIDTH-1 -: TAG_BITS];
    assign hit           = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign cpu_word_data = data_q[{cpu_idx, cpu_word}];

    always_comb begin
        store_merged = cpu_word_data;
        for (int b = 0; b < 4; b++) begin
            if (cpu_wr_en_i[b]) store_merged[8*b +: 8] = cpu_wr_data_i[8*b +: 8];
        end
    end

    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        base_d           = base_q;
        k_d              = k_q;
        req_word_d       = req_word_q;
        wr_addr_d        = wr_addr_q;
        wr_data_d        = wr_data_q;
        wr_en_d          = wr_en_q;
        arr_we           = 1'b0;
        arr_sel          = {cpu_idx, cpu_word};
        arr_wdata        = store_merged;
        tag_we           = 1'b0;
        pipeline_stall_o = 1'b0;
        cache_data_ack_o = 1'b0;
        cpu_rd_data_o    = '0;
        ram_rd_req_o     = 1'b0;
        ram_rd_addr_o    = '0;
        ram_wr_req_o     = 1'b0;
        ram_wr_addr_o    = '0;
        ram_wr_data_o    = '0;
        ram_wr_en_o      = '0;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    pipeline_stall_o = 1'b1;
                    arr_we           = hit;
                    wr_addr_d        = cpu_addr_i & WORD_MASK;
                    wr_data_d        = cpu_wr_data_i;
                    wr_en_d          = cpu_wr_en_i;
                    state_d          = WRITE;
                end else if (rd_req) begin
                    if (hit) begin
                        cache_data_ack_o = 1'b1;
                        cpu_rd_data_o    = cpu_word_data;
                    end else begin
                        // The victim line is invalidated up front so an aborted refill never leaves it valid.
                        pipeline_stall_o  = 1'b1;
                        base_d            = cpu_addr_i & LINE_MASK;
                        k_d               = '0;
                        req_word_d        = cpu_word;
                        valid_d[cpu_idx]  = 1'b0;
                        state_d           = REFILL;
                    end
                end
            end
            REFILL: begin
                pipeline_stall_o = 1'b1;
                ram_rd_req_o     = 1'b1;
                ram_rd_addr_o    = base_q | {{(ADDR_WIDTH-IDX_LSB){1'b0}}, k_q, 2'b00};
                if (ram_rd_valid_i) begin
                    arr_we    = 1'b1;
                    arr_sel   = {base_idx, k_q};
                    arr_wdata = ram_rd_data_i;
                    if (k_q == LAST_WORD) begin
                        tag_we            = 1'b1;
                        valid_d[base_idx] = 1'b1;
                        state_d           = RESP;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            RESP: begin
                cache_data_ack_o = 1'b1;
                cpu_rd_data_o    = data_q[{base_idx, req_word_q}];
                state_d          = IDLE;
            end
            WRITE: begin
                ram_wr_req_o  = 1'b1;
                ram_wr_addr_o = wr_addr_q;
                ram_wr_data_o = wr_data_q;
                ram_wr_en_o   = wr_en_q;
                if (ram_wr_ack_i) begin
                    cache_data_ack_o = 1'b1;
                    state_d          = IDLE;
                end else begin
                    pipeline_stall_o = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            base_q     <= '0;
            k_q        <= '0;
            req_word_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            base_q     <= base_d;
            k_q        <= k_d;
            req_word_q <= req_word_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
        end
    end

    // Tag and data arrays need no reset: the valid bits gate every use of them.
    always_ff @(posedge clk) begin
        if (arr_we) data_q[arr_sel] <= arr_wdata;
        if (tag_we) tag_q[base_idx] <= base_tag;
    end

`ifdef DCACHE_STAT_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == IDLE && rd_req && !wr_req) begin
            if (hit) hit_cnt_d  = hit_cnt_q + 32'd1;
            else     miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dcache_dm_wt.sv
// Randomised self-checking bench for dcache_dm_wt: a flat RAM image plus a line-residency table
// predict hits, refill traffic, returned data and counters.
module tb_dcache_dm_wt;
    localparam int LINE_NUM   = 64;
    localparam int LINE_WORDS = 4;
    localparam int LINE_BYTES = 4 * LINE_WORDS;
`ifdef DCACHE_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_rd_req_i, cpu_wr_req_i;
    logic [31:0] cpu_addr_i, cpu_wr_data_i;
    logic [3:0]  cpu_wr_en_i;
    logic [31:0] cpu_rd_data_o;
    logic        pipeline_stall_o, cache_data_ack_o;
    logic        ram_rd_req_o;
    logic [31:0] ram_rd_addr_o, ram_rd_data_i;
    logic        ram_rd_valid_i;
    logic        ram_wr_req_o;
    logic [31:0] ram_wr_addr_o, ram_wr_data_o;
    logic [3:0]  ram_wr_en_o;
    logic        ram_wr_ack_i;
    logic [31:0] hit_cnt_o, miss_cnt_o;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [int unsigned];
    bit          model_valid [LINE_NUM];
    logic [31:0] model_base  [LINE_NUM];
    logic [31:0] exp_hits, exp_misses;
    logic [31:0] last_rd_data;
    int          last_reads;

    dcache_dm_wt #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_NUM(LINE_NUM), .LINE_WORDS(LINE_WORDS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd_req_i(cpu_rd_req_i), .cpu_wr_req_i(cpu_wr_req_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wr_data_i(cpu_wr_data_i), .cpu_wr_en_i(cpu_wr_en_i), .cpu_rd_data_o(cpu_rd_data_o),
        .pipeline_stall_o(pipeline_stall_o), .cache_data_ack_o(cache_data_ack_o),
        .ram_rd_req_o(ram_rd_req_o), .ram_rd_addr_o(ram_rd_addr_o), .ram_rd_data_i(ram_rd_data_i),
        .ram_rd_valid_i(ram_rd_valid_i), .ram_wr_req_o(ram_wr_req_o), .ram_wr_addr_o(ram_wr_addr_o),
        .ram_wr_data_o(ram_wr_data_o), .ram_wr_en_o(ram_wr_en_o), .ram_wr_ack_i(ram_wr_ack_i),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < LINE_NUM; i++) model_valid[i] = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
    endfunction

    task automatic check_counters();
        checkOutput("hit_cnt", 64'(hit_cnt_o), 64'(STAT_EN ? exp_hits : 32'd0));
        checkOutput("miss_cnt", 64'(miss_cnt_o), 64'(STAT_EN ? exp_misses : 32'd0));
    endtask

    // One CPU transaction with the bench acting as RAM; abort_after>0 resets mid-refill after that many words.
    task automatic applyStimulus(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] en, input int min_dly, input int max_dly,
                                 input int abort_after);
        logic [31:0] line_base, merged;
        int          idx, reads, delay, cyc;
        bit          expect_hit, done;
        line_base  = addr & ~(32'(LINE_BYTES) - 32'd1);
        idx        = int'((addr / LINE_BYTES) % LINE_NUM);
        expect_hit = model_valid[idx] && (model_base[idx] == line_base);
        reads      = 0;
        delay      = $urandom_range(max_dly, min_dly);
        done       = 1'b0;
        @(negedge clk);
        cpu_addr_i    = addr;
        cpu_rd_req_i  = !is_wr;
        cpu_wr_req_i  = is_wr;
        cpu_wr_data_i = wdata;
        cpu_wr_en_i   = en;
        for (cyc = 0; cyc < 200 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            ram_rd_valid_i = 1'b0;
            ram_wr_ack_i   = 1'b0;
            if (abort_after > 0 && reads == abort_after) begin
                rst_n = 1'b0;
                #1;
                checkOutput("abort_ctl", 64'({pipeline_stall_o, cache_data_ack_o, ram_rd_req_o, ram_wr_req_o}), 64'd0);
                checkOutput("abort_addr", 64'({ram_rd_addr_o, ram_wr_addr_o}), 64'd0);
                checkOutput("abort_data", 64'({cpu_rd_data_o, ram_wr_data_o}), 64'd0);
                model_reset();
                check_counters();
                cpu_rd_req_i = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                done  = 1'b1;
            end else if (is_wr) begin
                ram_rd_valid_i = 1'($urandom_range(1, 0));
                #1;
                if (ram_wr_req_o) begin
                    checkOutput("wr_addr", 64'(ram_wr_addr_o), 64'(addr));
                    checkOutput("wr_data_en", 64'({ram_wr_data_o, ram_wr_en_o}), 64'({wdata, en}));
                    if (delay == 0) begin
                        ram_wr_ack_i = 1'b1;
                        #1;
                        checkOutput("wr_ack_cycle", 64'({pipeline_stall_o, cache_data_ack_o}), 64'b01);
                        merged = mem_rd(addr);
                        for (int b = 0; b < 4; b++) if (en[b]) merged[8*b +: 8] = wdata[8*b +: 8];
                        mem[addr] = merged;
                        done = 1'b1;
                    end else begin
                        delay--;
                        checkOutput("wr_wait", 64'({pipeline_stall_o, cache_data_ack_o}), 64'b10);
                    end
                end else begin
                    checkOutput("wr_capture", 64'({pipeline_stall_o, cache_data_ack_o, ram_rd_req_o}), 64'b100);
                end
            end else begin
                ram_wr_ack_i = 1'($urandom_range(1, 0));
                #1;
                if (cache_data_ack_o) begin
                    checkOutput("ld_data", 64'(cpu_rd_data_o), 64'(mem_rd(addr)));
                    checkOutput("ld_ack_stall", 64'(pipeline_stall_o), 64'd0);
                    checkOutput("ld_hit_latency", 64'(cyc == 0), 64'(expect_hit));
                    checkOutput("ld_reads", 64'(reads), 64'(expect_hit ? 0 : LINE_WORDS));
                    last_rd_data = cpu_rd_data_o;
                    if (expect_hit) exp_hits++;
                    else begin
                        exp_misses++;
                        model_valid[idx] = 1'b1;
                        model_base[idx]  = line_base;
                    end
                    done = 1'b1;
                end else begin
                    checkOutput("ld_stall", 64'(pipeline_stall_o), 64'd1);
                    if (ram_rd_req_o) begin
                        checkOutput("rd_addr", 64'(ram_rd_addr_o), 64'(line_base + 32'(4 * reads)));
                        if (delay == 0) begin
                            ram_rd_valid_i = 1'b1;
                            ram_rd_data_i  = mem_rd(ram_rd_addr_o);
                            reads++;
                            delay = $urandom_range(max_dly, min_dly);
                        end else begin
                            delay--;
                        end
                    end
                end
            end
        end
        if (!done) checkOutput("timeout", 64'd0, 64'd1);
        last_reads = reads;
        @(negedge clk);
        cpu_rd_req_i   = 1'b0;
        cpu_wr_req_i   = 1'b0;
        ram_rd_valid_i = 1'b0;
        ram_wr_ack_i   = 1'b0;
        #1;
        check_counters();
    endtask

    task automatic idle_gap(input int n);
        for (int g = 0; g < n; g++) begin
            @(negedge clk);
            ram_rd_valid_i = 1'($urandom_range(1, 0));
            ram_wr_ack_i   = 1'($urandom_range(1, 0));
            ram_rd_data_i  = $urandom;
            #1;
            checkOutput("idle_quiet", 64'({pipeline_stall_o, cache_data_ack_o, ram_rd_req_o, ram_wr_req_o}), 64'd0);
        end
        @(negedge clk);
        ram_rd_valid_i = 1'b0;
        ram_wr_ack_i   = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        bit          rw;
        rst_n = 1'b0;
        cpu_rd_req_i = 1'b0; cpu_wr_req_i = 1'b0; cpu_addr_i = '0;
        cpu_wr_data_i = '0; cpu_wr_en_i = '0;
        ram_rd_data_i = '0; ram_rd_valid_i = 1'b0; ram_wr_ack_i = 1'b0;
        last_rd_data = '0; last_reads = 0;
        for (int k = 0; k < LINE_WORDS; k++) mem[32'h100 + 4 * k] = 32'hA0 + k;
        model_reset();
        #23;
        checkOutput("reset_ctl", 64'({pipeline_stall_o, cache_data_ack_o, ram_rd_req_o, ram_wr_req_o}), 64'd0);
        checkOutput("reset_data", 64'({cpu_rd_data_o, ram_rd_addr_o}), 64'd0);
        check_counters();
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(1'b0, 32'h100, '0, 4'h0, 0, 2, 0);
        checkOutput("plan_first_data", 64'(last_rd_data), 64'h0A0);
        checkOutput("plan_first_reads", 64'(last_reads), 64'(LINE_WORDS));
        applyStimulus(1'b0, 32'h108, '0, 4'h0, 0, 2, 0);
        checkOutput("plan_hit_data", 64'(last_rd_data), 64'h0A2);
        applyStimulus(1'b1, 32'h104, 32'hDEADBEEF, 4'b0011, 3, 3, 0);
        applyStimulus(1'b0, 32'h104, '0, 4'h0, 0, 2, 0);
        checkOutput("plan_merge", 64'(last_rd_data), 64'h0000BEEF);
        checkOutput("plan_merge_hit", 64'(last_reads), 64'd0);

        applyStimulus(1'b0, 32'h100 + 32'(LINE_BYTES * LINE_NUM), '0, 4'h0, 0, 1, 0);
        checkOutput("conflict_evict", 64'(last_reads), 64'(LINE_WORDS));
        applyStimulus(1'b0, 32'h100, '0, 4'h0, 0, 1, 0);
        checkOutput("conflict_reload", 64'(last_reads), 64'(LINE_WORDS));

        applyStimulus(1'b1, 32'h2000, 32'h12345678, 4'b1111, 0, 2, 0);
        applyStimulus(1'b0, 32'h2000, '0, 4'h0, 0, 1, 0);
        checkOutput("store_miss_noalloc", 64'(last_reads), 64'(LINE_WORDS));
        applyStimulus(1'b1, 32'h108, 32'hFFFFFFFF, 4'b0000, 0, 0, 0);
        applyStimulus(1'b0, 32'h108, '0, 4'h0, 0, 0, 0);
        checkOutput("store_en0", 64'(last_rd_data), 64'h0A2);

        applyStimulus(1'b0, 32'h300, '0, 4'h0, 0, 1, 2);
        applyStimulus(1'b0, 32'h300, '0, 4'h0, 0, 1, 0);
        checkOutput("abort_full_refill", 64'(last_reads), 64'(LINE_WORDS));

        // Counter scenario on top of the post-abort state: 0x300 is resident, so two more misses make three.
        applyStimulus(1'b0, 32'h140, '0, 4'h0, 0, 1, 0);
        applyStimulus(1'b0, 32'h180, '0, 4'h0, 0, 1, 0);
        applyStimulus(1'b0, 32'h304, '0, 4'h0, 0, 1, 0);
        applyStimulus(1'b0, 32'h308, '0, 4'h0, 0, 1, 0);
        applyStimulus(1'b0, 32'h144, '0, 4'h0, 0, 1, 0);
        applyStimulus(1'b0, 32'h188, '0, 4'h0, 0, 1, 0);
        applyStimulus(1'b0, 32'h300, '0, 4'h0, 0, 1, 0);
        checkOutput("stat_misses", 64'(miss_cnt_o), 64'(STAT_EN ? 3 : 0));
        checkOutput("stat_hits", 64'(hit_cnt_o), 64'(STAT_EN ? 5 : 0));

        for (int t = 0; t < 200; t++) begin
            rw = ($urandom_range(9, 0) < 4);
            if ($urandom_range(9, 0) == 0) ra = 32'h2000 + 32'($urandom_range(63, 0)) * 4;
            else                           ra = 32'($urandom_range(511, 0)) * 4;
            applyStimulus(rw, ra, $urandom, 4'($urandom_range(15, 0)), 0, 3, 0);
            idle_gap($urandom_range(2, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dcache_dm_wt.md
Name: dcache_dm_wt

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache between the execute stage's load/store port and data RAM.
- Successor to the fixed-size cache_top slot in the core top level.
- Adds configurable geometry, a burst line-refill FSM with a RAM valid/ack handshake, and a pipeline stall output.
- Hits complete in zero stall cycles; misses and stores stall the pipeline until serviced.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width; fixed at 32 (4 byte enables).
- LINE_NUM, 64, number of cache lines; power of two, at least 2.
- LINE_WORDS, 4, words per line; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_rd_req_i  in  1  load request.
- cpu_wr_req_i  in  1  store request.
- cpu_addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored.
- cpu_wr_data_i  in  DATA_WIDTH  store data.
- cpu_wr_en_i  in  4  store byte enables.
- cpu_rd_data_o  out  DATA_WIDTH  load data, valid when cache_data_ack_o=1.
- pipeline_stall_o  out  1  freeze pipeline.
- cache_data_ack_o  out  1  request completed this cycle.
- ram_rd_req_o  out  1  RAM word read request.
- ram_rd_addr_o  out  ADDR_WIDTH  RAM read address.
- ram_rd_data_i  in  DATA_WIDTH  RAM read data.
- ram_rd_valid_i  in  1  ram_rd_data_i valid.
- ram_wr_req_o  out  1  RAM write request.
- ram_wr_addr_o  out  ADDR_WIDTH  RAM write address.
- ram_wr_data_o  out  DATA_WIDTH  RAM write data.
- ram_wr_en_o  out  4  RAM byte enables.
- ram_wr_ack_i  in  1  RAM write accepted.
- hit_cnt_o  out  32  load-hit count (see Optional Feature).
- miss_cnt_o  out  32  load-miss count (see Optional Feature).

Behaviour:
- Address split: offset = 2 bits; word = log2(LINE_WORDS) bits; index = log2(LINE_NUM) bits; tag = the remaining bits.
- Storage: flop arrays for valid, tag and data. Lookup is combinational.
- Reset: all valid bits cleared; state=IDLE; every output 0. A reset during REFILL or WRITE aborts the operation, and no partial line is left valid.
- Requestor rule: the pipeline holds request, address and data stable while pipeline_stall_o=1.
- Simultaneous rd and wr requests: the store is serviced first; the load is then serviced as a new request.
- IDLE, load hit: cache_data_ack_o=1 and cpu_rd_data_o=line word in the same cycle; stall=0; 0-cycle penalty.
- IDLE, load miss: stall=1 combinationally. Latch the line base address (word and offset bits zeroed); go to REFILL.
- REFILL:
  - Word counter k counts 0..LINE_WORDS-1.
  - ram_rd_req_o=1 and ram_rd_addr_o=base+4k, held until ram_rd_valid_i.
  - On valid: store the word at k, increment k.
  - After the last word: write the tag, set valid, go to RESP.
  - stall=1 throughout.
- RESP (1 cycle): ack=1, cpu_rd_data_o=requested word, stall=0; return to IDLE.
- IDLE, store:
  - stall=1. On a hit, merge the enabled bytes into the cached word (in the capture cycle). On a miss, the cache is unchanged.
  - Latch address, data and byte enables; go to WRITE.
- WRITE:
  - ram_wr_req_o=1 with the latched addr/data/en, held until ram_wr_ack_i.
  - The ack cycle: cache_data_ack_o=1, stall=0; return to IDLE next.
  - An ack arriving in the first WRITE cycle is legal.
- No request in IDLE: stall=0, ack=0.
- ram_rd_valid_i outside REFILL and ram_wr_ack_i outside WRITE are ignored.
- cpu_wr_en_i=0 on a store: the RAM write is still issued (with en=0), and the store is acked.

Optional Feature:
- Macro: DCACHE_STAT_EN.
- Defined: hit_cnt_o increments on each IDLE load hit; miss_cnt_o increments on each load miss entering REFILL. Both are 32-bit, wrap at 2^32, and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Load 0x100 after reset (RAM word at 0x100+4k = 0xA0+k) -> stall through 4 read handshakes at 0x100/104/108/10C, RESP ack with data 0xA0; a following load of 0x108 hits with ack the same cycle, data 0xA2, stall=0.
- Store 0x104, data 0xDEADBEEF, en=4'b0011, on the cached line -> RAM write with en=0011 held until ack (ack delayed 3 cycles); a later load of 0x104 hits, returning 0x0000BEEF merged over 0xA1 (i.e. 0x0000BEEF with bits 31:16 = 0x0000 from 0xA1).
- Conflict: load 0x100, then load 0x100+4*LINE_WORDS*LINE_NUM (0x500 at defaults) -> second load misses and refills; the reload of 0x100 misses again.
- Store miss to 0x2000 -> RAM write issued, cache valid bits unchanged; a load of 0x2000 then misses.
- Assert rst_n=0 after the 2nd refill word -> outputs 0, state IDLE; a reload of the same address misses and performs a full 4-word refill.
- DCACHE_STAT_EN defined: 3 misses + 5 hits -> miss_cnt_o=3, hit_cnt_o=5. Undefined -> both read 0.
